wb_checker: RTL
===============

WB_CHECKER -- requirements
Module: wb_checker

Interface
REQ-001 Parameter DATA_W, default 32: width of compared write data.
REQ-002 Parameter ADDR_W, default 7: width of compared write address/index.
REQ-003 Parameter CH, default 2: number of independent writeback channels (ch0 = register file, ch1 = data memory).
REQ-004 Parameter DEPTH, default 16 (power of 2, >=2): expected-event FIFO depth per channel.
REQ-005 Parameter TIMEOUT, default 64: cycles a non-empty FIFO may wait for an actual event.
REQ-006 Parameter STOP_ON_ERR, default 1: 1 = enter FAIL on first error; 0 = count errors and continue.
REQ-007 clk_i  in  1  single clock; all state changes on rising edge.
REQ-008 rst_i  in  1  reset, asynchronous and active-high.
REQ-009 start_i  in  1  one-cycle pulse; begins a check run.
REQ-010 end_i  in  1  one-cycle pulse; program finished (no further actual events).
REQ-011 exp_valid_i  in  CH  expected-event valid per channel (reference model side).
REQ-012 exp_ready_o  out  CH  channel FIFO can accept an expected event.
REQ-013 exp_addr_i / exp_data_i  in  CH*ADDR_W / CH*DATA_W  expected address/data, channel c in slice c.
REQ-014 act_valid_i  in  CH  actual DUT write strobe per channel; no backpressure.
REQ-015 act_addr_i / act_data_i  in  CH*ADDR_W / CH*DATA_W  actual address/data.
REQ-016 busy_o, pass_o, fail_o  out  1 each  run status.
REQ-017 err_code_o  out  3  first error cause: 0 none, 1 data/addr mismatch, 2 underflow, 3 timeout, 4 leftover at end, 5 overflow push.
REQ-018 err_cnt_o  out  16  total errors, saturating at 16'hFFFF.
REQ-019 err_ch_o / err_addr_o / err_exp_o / err_act_o  out  $clog2(CH) / ADDR_W / DATA_W / DATA_W  capture of first error.

Function
REQ-020 FSM states IDLE, RUN, DRAIN, PASS, FAIL; IDLE->RUN on start_i; RUN->DRAIN on end_i; DRAIN->PASS when all FIFOs empty and err_cnt_o==0; DRAIN->FAIL on leftover check; RUN/DRAIN->FAIL on first error when STOP_ON_ERR=1.
REQ-021 PASS and FAIL are sticky until start_i, which clears FIFOs, counters, captures and enters RUN next cycle.
REQ-022 busy_o=1 in RUN and DRAIN; pass_o=1 only in PASS; fail_o=1 only in FAIL.
REQ-023 Expected push when exp_valid_i[c] & exp_ready_o[c]; exp_ready_o[c]=0 when FIFO c full or state not RUN.
REQ-024 exp_valid_i[c] while FIFO c full in RUN is an overflow error (code 5); event dropped.
REQ-025 act_valid_i[c] pops FIFO c head and compares address and data in the same cycle; any bit differing is a mismatch (code 1).
REQ-026 act_valid_i[c] with FIFO c empty is underflow (code 2); no bypass: an expected push in the same cycle does not satisfy it.
REQ-027 Simultaneous push and pop on a non-empty FIFO keeps occupancy unchanged.
REQ-028 Per-channel wait counter increments each RUN/DRAIN cycle FIFO c is non-empty without act_valid_i[c], resets on pop; reaching TIMEOUT is code 3, counter then restarts.
REQ-029 In DRAIN, one cycle after entry, any non-empty FIFO is code 4 (one error per non-empty channel).
REQ-030 Errors from several channels in one cycle each increment err_cnt_o; capture and err_code_o take lowest-numbered channel, only if no prior error.
REQ-031 act_valid_i outside RUN/DRAIN is ignored; with STOP_ON_ERR=0 end state is FAIL iff err_cnt_o!=0.

Reset
REQ-032 rst_i asserted: state IDLE, all FIFOs empty, exp_ready_o=0, busy_o=pass_o=fail_o=0, err_code_o=0, err_cnt_o=0, all capture outputs 0, wait counters 0; takes effect immediately, including mid-run.

Structure
REQ-033 Package wb_chk_pkg holds the state enum and error-code constants.
REQ-034 One sub-module chk_fifo (DEPTH x (ADDR_W+DATA_W), full/empty flags, same async reset), instantiated CH times by generate.

Verification
REQ-035 start; ch0 push (3,5),(4,7); act (3,5),(4,7); end -> PASS, err_cnt_o=0.
REQ-036 ch1 push (8,0x11); act (8,0x12) -> FAIL next cycle, err_code_o=1, err_ch_o=1, err_exp_o=0x11, err_act_o=0x12.
REQ-037 act ch0 with empty FIFO and same-cycle push -> err_code_o=2; STOP_ON_ERR=0 variant: run continues, err_cnt_o=1, end -> FAIL.
REQ-038 push ch0 one entry, no act for 64 cycles -> err_code_o=3 at cycle 64; push 17 entries into DEPTH=16 -> exp_ready_o[0]=0, code 5.
REQ-039 push ch0 two entries, act one, end -> code 4; rst_i pulse mid-RUN -> IDLE, all outputs 0 same cycle.

Source files
------------

// File: rtl/wb_chk_pkg.sv
// Shared types for the writeback checker: run-state encoding and first-error cause codes.
// Pure declarations; no latency or backpressure of its own.
package wb_chk_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_PASS,
    ST_FAIL
  } state_e;

  localparam logic [2:0] ERR_NONE      = 3'd0;
  localparam logic [2:0] ERR_MISMATCH  = 3'd1;
  localparam logic [2:0] ERR_UNDERFLOW = 3'd2;
  localparam logic [2:0] ERR_TIMEOUT   = 3'd3;
  localparam logic [2:0] ERR_LEFTOVER  = 3'd4;
  localparam logic [2:0] ERR_OVERFLOW  = 3'd5;

endpackage

// File: rtl/chk_fifo.sv
// Expected-event FIFO: push visible at the head one cycle later, head read combinationally.
// Push while full and pop while empty are dropped; clr_i empties it synchronously.
module chk_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 39
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   clr_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [W-1:0]           wdat_i,
  output logic [W-1:0]           rdat_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] cnt_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q;
  logic          do_push, do_pop;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign cnt_o   = cnt_q;
  assign rdat_o  = mem_q[rd_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (clr_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= wdat_i;
  end

endmodule

// File: rtl/wb_checker.sv
// Writeback checker: matches DUT write events per channel against queued reference events; errors register one cycle after the event.
// Reference side is held off only by a full channel FIFO or a non-RUN state; the actual side is never backpressured.
module wb_checker
  import wb_chk_pkg::*;
#(
  parameter int  DATA_W      = 32,
  parameter int  ADDR_W      = 7,
  parameter int  CH          = 2,
  parameter int  DEPTH       = 16,
  parameter int  TIMEOUT     = 64,
  parameter int  STOP_ON_ERR = 1,
  localparam int CHW         = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic                 end_i,
  input  logic [CH-1:0]        exp_valid_i,
  output logic [CH-1:0]        exp_ready_o,
  input  logic [CH*ADDR_W-1:0] exp_addr_i,
  input  logic [CH*DATA_W-1:0] exp_data_i,
  input  logic [CH-1:0]        act_valid_i,
  input  logic [CH*ADDR_W-1:0] act_addr_i,
  input  logic [CH*DATA_W-1:0] act_data_i,
  output logic                 busy_o,
  output logic                 pass_o,
  output logic                 fail_o,
  output logic [2:0]           err_code_o,
  output logic [15:0]          err_cnt_o,
  output logic [CHW-1:0]       err_ch_o,
  output logic [ADDR_W-1:0]    err_addr_o,
  output logic [DATA_W-1:0]    err_exp_o,
  output logic [DATA_W-1:0]    err_act_o
);

  localparam int EW = ADDR_W + DATA_W;
  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);

  state_e                  state_q, state_d;
  logic                    run, drain, active, clear;
  logic [CH-1:0]           push, pop, full, empty;
  logic [CH-1:0]           e_mm, e_uf, e_to, e_lo, e_of;
  logic [CH-1:0][EW-1:0]   head;
  logic [CH-1:0][AW:0]     fifo_cnt;
  logic [CH-1:0][TW-1:0]   wait_q, wait_d;
  logic [CH-1:0][2:0]      cand_code;
  logic [CH-1:0][ADDR_W-1:0] cand_addr;
  logic [CH-1:0][DATA_W-1:0] cand_exp, cand_act;

  logic [15:0]       err_cnt_q, err_cnt_d;
  logic [2:0]        err_code_q, err_code_d;
  logic [CHW-1:0]    err_ch_q, err_ch_d;
  logic [ADDR_W-1:0] err_addr_q, err_addr_d;
  logic [DATA_W-1:0] err_exp_q, err_exp_d, err_act_q, err_act_d;

  int                n_err;
  logic [16:0]       cnt_sum;
  logic [2:0]        sel_code;
  logic [CHW-1:0]    sel_ch;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_exp, sel_act;

  assign run    = (state_q == ST_RUN);
  assign drain  = (state_q == ST_DRAIN);
  assign active = run | drain;
  assign clear  = start_i & ((state_q == ST_IDLE) | (state_q == ST_PASS) | (state_q == ST_FAIL));

  for (genvar c = 0; c < CH; c++) begin : g_ch
    logic [ADDR_W-1:0] a_addr, h_addr, x_addr;
    logic [DATA_W-1:0] a_data, h_data, x_data;
    logic              stalled;

    assign a_addr = act_addr_i[c*ADDR_W +: ADDR_W];
    assign a_data = act_data_i[c*DATA_W +: DATA_W];
    assign x_addr = exp_addr_i[c*ADDR_W +: ADDR_W];
    assign x_data = exp_data_i[c*DATA_W +: DATA_W];
    assign {h_addr, h_data} = head[c];

    assign push[c] = run & exp_valid_i[c] & ~full[c];
    assign pop[c]  = active & act_valid_i[c] & ~empty[c];

    chk_fifo #(.DEPTH(DEPTH), .W(EW)) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .clr_i   (clear),
      .push_i  (push[c]),
      .pop_i   (pop[c]),
      .wdat_i  ({x_addr, x_data}),
      .rdat_o  (head[c]),
      .full_o  (full[c]),
      .empty_o (empty[c]),
      .cnt_o   (fifo_cnt[c])
    );

    // Underflow looks at pre-push emptiness, so a same-cycle push never rescues it.
    assign stalled  = active & ~empty[c] & ~act_valid_i[c];
    assign e_mm[c]  = pop[c] & (head[c] != {a_addr, a_data});
    assign e_uf[c]  = active & act_valid_i[c] & empty[c];
    assign e_to[c]  = stalled & (wait_q[c] == TW'(TIMEOUT - 1));
    assign e_lo[c]  = drain & (fifo_cnt[c] != (AW+1)'(pop[c]));
    assign e_of[c]  = run & exp_valid_i[c] & full[c];
    assign wait_d[c] = (stalled & ~e_to[c]) ? wait_q[c] + TW'(1) : '0;

    assign cand_code[c] = e_mm[c] ? ERR_MISMATCH  :
                          e_uf[c] ? ERR_UNDERFLOW :
                          e_to[c] ? ERR_TIMEOUT   :
                          e_lo[c] ? ERR_LEFTOVER  :
                          e_of[c] ? ERR_OVERFLOW  : ERR_NONE;
    assign cand_addr[c] = (e_mm[c] | e_uf[c]) ? a_addr :
                          (e_to[c] | e_lo[c]) ? h_addr : x_addr;
    assign cand_exp[c]  = e_uf[c] ? '0 :
                          (e_mm[c] | e_to[c] | e_lo[c]) ? h_data : x_data;
    assign cand_act[c]  = (e_mm[c] | e_uf[c]) ? a_data : '0;
  end

  assign exp_ready_o = run ? ~full : '0;

  always_comb begin
    state_d    = state_q;
    err_cnt_d  = err_cnt_q;
    err_code_d = err_code_q;
    err_ch_d   = err_ch_q;
    err_addr_d = err_addr_q;
    err_exp_d  = err_exp_q;
    err_act_d  = err_act_q;
    n_err      = $countones({e_mm, e_uf, e_to, e_lo, e_of});
    cnt_sum    = {1'b0, err_cnt_q} + 17'(n_err);
    sel_code   = ERR_NONE;
    sel_ch     = '0;
    sel_addr   = '0;
    sel_exp    = '0;
    sel_act    = '0;
    // Walk downwards so the lowest-numbered failing channel wins.
    for (int c = CH - 1; c >= 0; c--) begin
      if (cand_code[c] != ERR_NONE) begin
        sel_code = cand_code[c];
        sel_ch   = CHW'(c);
        sel_addr = cand_addr[c];
        sel_exp  = cand_exp[c];
        sel_act  = cand_act[c];
      end
    end

    if (clear) begin
      state_d    = ST_RUN;
      err_cnt_d  = '0;
      err_code_d = ERR_NONE;
      err_ch_d   = '0;
      err_addr_d = '0;
      err_exp_d  = '0;
      err_act_d  = '0;
    end else begin
      err_cnt_d = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
      if ((err_code_q == ERR_NONE) && (sel_code != ERR_NONE)) begin
        err_code_d = sel_code;
        err_ch_d   = sel_ch;
        err_addr_d = sel_addr;
        err_exp_d  = sel_exp;
        err_act_d  = sel_act;
      end
      case (state_q)
        ST_RUN: begin
          if ((STOP_ON_ERR != 0) && (n_err != 0)) state_d = ST_FAIL;
          else if (end_i)                         state_d = ST_DRAIN;
        end
        ST_DRAIN: state_d = (err_cnt_d != '0) ? ST_FAIL : ST_PASS;
        default:  state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      wait_q     <= '0;
      err_cnt_q  <= '0;
      err_code_q <= ERR_NONE;
      err_ch_q   <= '0;
      err_addr_q <= '0;
      err_exp_q  <= '0;
      err_act_q  <= '0;
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      err_cnt_q  <= err_cnt_d;
      err_code_q <= err_code_d;
      err_ch_q   <= err_ch_d;
      err_addr_q <= err_addr_d;
      err_exp_q  <= err_exp_d;
      err_act_q  <= err_act_d;
    end
  end

  assign busy_o     = active;
  assign pass_o     = (state_q == ST_PASS);
  assign fail_o     = (state_q == ST_FAIL);
  assign err_code_o = err_code_q;
  assign err_cnt_o  = err_cnt_q;
  assign err_ch_o   = err_ch_q;
  assign err_addr_o = err_addr_q;
  assign err_exp_o  = err_exp_q;
  assign err_act_o  = err_act_q;

endmodule
